// File: rtl/aes_inv_mixcolumns_iter.sv
// aes_inv_mixcolumns_iter: iterative AES InvMixColumns, COLS_PER_CYCLE columns per clock
module aes_inv_mixcolumns_iter #(
    parameter int COLS_PER_CYCLE = 1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clear,
    input  logic [127:0] imx_i,
    input  logic         in_valid,
    output logic         in_ready,
    output logic [127:0] imx_o,
    output logic         out_valid,
    input  logic         out_ready
);
    localparam logic [2:0] CPC = 3'(COLS_PER_CYCLE);

    generate
        if (COLS_PER_CYCLE != 1 && COLS_PER_CYCLE != 2 && COLS_PER_CYCLE != 4) begin : g_bad_cols
            $error("COLS_PER_CYCLE must be 1, 2 or 4");
        end
    endgenerate

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t       st;
    logic [1:0]   cnt;
    logic [127:0] sreg;
    logic [127:0] nxt;
    logic         acc;
    logic         last;

    function automatic logic [7:0] xt(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    // k selects which of a, 2a, 4a, 8a are summed, so 09/0b/0d/0e need only three xtimes
    function automatic logic [7:0] gm(input logic [7:0] a, input logic [3:0] k);
        logic [7:0] a2, a4, a8;
        a2 = xt(a);
        a4 = xt(a2);
        a8 = xt(a4);
        return ({8{k[0]}} & a) ^ ({8{k[1]}} & a2) ^ ({8{k[2]}} & a4) ^ ({8{k[3]}} & a8);
    endfunction

    function automatic logic [31:0] inv_col(input logic [31:0] c);
        logic [7:0] a0, a1, a2, a3;
        {a0, a1, a2, a3} = c;
        return {gm(a0, 4'he) ^ gm(a1, 4'hb) ^ gm(a2, 4'hd) ^ gm(a3, 4'h9),
                gm(a0, 4'h9) ^ gm(a1, 4'he) ^ gm(a2, 4'hb) ^ gm(a3, 4'hd),
                gm(a0, 4'hd) ^ gm(a1, 4'h9) ^ gm(a2, 4'he) ^ gm(a3, 4'hb),
                gm(a0, 4'hb) ^ gm(a1, 4'hd) ^ gm(a2, 4'h9) ^ gm(a3, 4'he)};
    endfunction

    assign in_ready  = !clear && (st == IDLE || (st == DONE && out_ready));
    assign acc       = in_valid && in_ready;
    assign last      = ({1'b0, cnt} + CPC) == 3'd4;
    assign out_valid = st == DONE;
    assign imx_o     = sreg;

    // transform only the columns inside this cycle's window, pass the rest through
    always_comb begin
        nxt = sreg;
        for (int c = 0; c < 4; c++)
            if ({1'b0, 2'(c) - cnt} < CPC) nxt[127-32*c -: 32] = inv_col(sreg[127-32*c -: 32]);
    end

    // control FSM and in-place state register; clear keeps the register contents
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            st   <= IDLE;
            cnt  <= '0;
            sreg <= '0;
        end else if (clear) begin
            st  <= IDLE;
            cnt <= '0;
        end else if (acc) begin
            st   <= BUSY;
            cnt  <= '0;
            sreg <= imx_i;
        end else if (st == BUSY) begin
            sreg <= nxt;
            cnt  <= cnt + CPC[1:0];
            if (last) st <= DONE;
        end else if (st == DONE && out_ready) begin
            st <= IDLE;
        end
    end
endmodule

// File: tb/tb_aes_inv_mixcolumns_iter.sv
// tb_aes_inv_mixcolumns_iter: scoreboard bench over COLS_PER_CYCLE = 1, 2, 4
module tb_aes_inv_mixcolumns_iter;
    logic clk = 0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int ndone = 0;

    localparam logic [127:0] V1 = 128'h8e4da1bc_9fdc589d_01010101_d5d5d7d6;
    localparam logic [127:0] E1 = 128'hdb135345_f20a225c_01010101_d4d4d4d5;
    localparam logic [127:0] V2 = 128'h4d7ebdf8_c6c6c6c6_d5d5d7d6_01010101;
    localparam logic [127:0] E2 = 128'h2d26314c_c6c6c6c6_d4d4d4d5_01010101;

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        p = 0;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p ^= a;
            a = {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    // forward MixColumns: row r uses the circulant row {02,03,01,01} rotated right by r
    function automatic logic [127:0] mix(input logic [127:0] s);
        logic [7:0]   m [4];
        logic [127:0] o;
        logic [7:0]   acc;
        m = '{8'h02, 8'h03, 8'h01, 8'h01};
        o = 0;
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++) begin
                acc = 0;
                for (int j = 0; j < 4; j++) acc ^= gmul(m[(j - r + 4) % 4], s[127-32*c-8*j -: 8]);
                o[127-32*c-8*r -: 8] = acc;
            end
        return o;
    endfunction

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    for (genvar g = 0; g < 3; g++) begin : u
        localparam int C = 1 << g;
        localparam int L = 4 / C;
        logic         rst_n = 0, clear = 0, iv = 0, ordy = 0, rnd = 0;
        logic         ir, ov;
        logic [127:0] din = 0, dout;
        logic [127:0] q[$];
        logic         held = 0;
        logic [127:0] hv = 0;

        aes_inv_mixcolumns_iter #(.COLS_PER_CYCLE(C)) dut (
            .clk(clk), .rst_n(rst_n), .clear(clear), .imx_i(din), .in_valid(iv),
            .in_ready(ir), .imx_o(dout), .out_valid(ov), .out_ready(ordy)
        );

        always @(negedge clk) begin
            if (held && rst_n) chk($sformatf("hold C=%0d", C), ov ? dout : ~hv, hv);
            if (ov && ordy) begin
                if (q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL spurious C=%0d: got %h want none", C, dout);
                end else chk($sformatf("result C=%0d", C), dout, q.pop_front());
            end
            held = ov && !ordy && rst_n;
            hv   = dout;
        end

        task automatic send(input logic [127:0] d, input logic [127:0] e, input bit push, output int w);
            din = d;
            iv  = 1;
            w   = 0;
            forever begin
                @(negedge clk);
                w++;
                if (ir || w >= 200) break;
                @(posedge clk);
                #1;
                if (rnd) ordy = $urandom_range(0, 2) != 0;
            end
            if (!ir) begin
                total++;
                bad++;
                $display("FAIL send_timeout C=%0d: got no in_ready want in_ready", C);
            end else if (push) q.push_back(e);
            @(posedge clk);
            #1;
            iv = 0;
        endtask

        task automatic lat(input string nm, input int exp);
            int k;
            k = 0;
            forever begin
                @(negedge clk);
                if (ov || k >= 50) break;
                k++;
            end
            chk($sformatf("%s C=%0d", nm, C), 128'(k), 128'(exp));
        endtask

        initial begin
            int w;
            logic [127:0] s;
            #23;
            chk($sformatf("rst_dout C=%0d", C), dout, 0);
            chk($sformatf("rst_ov C=%0d", C), 128'(ov), 0);
            chk($sformatf("rst_ir C=%0d", C), 128'(ir), 1);
            @(posedge clk); #1;
            rst_n = 1;
            ordy  = 1;
            send(V1, E1, 1, w);
            lat("lat", L);
            @(posedge clk); #1;
            ordy = 0;
            send(V1, E1, 1, w);
            lat("lat_bp", L);
            repeat (10) begin
                @(posedge clk); #1;
                iv  = 1;
                din = V2;
                @(negedge clk);
                chk($sformatf("bp_ir C=%0d", C), 128'(ir), 0);
            end
            @(posedge clk); #1;
            iv   = 0;
            ordy = 1;
            @(negedge clk);
            @(negedge clk);
            chk($sformatf("bp_idle_ov C=%0d", C), 128'(ov), 0);
            chk($sformatf("bp_idle_ir C=%0d", C), 128'(ir), 1);
            @(posedge clk); #1;
            send(V1, E1, 1, w);
            send(V2, E2, 1, w);
            chk($sformatf("b2b_wait C=%0d", C), 128'(w), 128'(L + 1));
            lat("lat_b2b", L);
            @(posedge clk); #1;
            send(V1, 0, 0, w);
            if (L > 1) begin
                @(posedge clk); #1;
            end
            clear = 1;
            @(posedge clk); #1;
            clear = 0;
            @(negedge clk);
            chk($sformatf("clr_ov C=%0d", C), 128'(ov), 0);
            chk($sformatf("clr_ir C=%0d", C), 128'(ir), 1);
            repeat (L + 2) begin
                @(negedge clk);
                chk($sformatf("clr_quiet C=%0d", C), 128'(ov), 0);
            end
            @(posedge clk); #1;
            clear = 1;
            iv    = 1;
            din   = V1;
            @(negedge clk);
            chk($sformatf("clr_blocks_ir C=%0d", C), 128'(ir), 0);
            @(posedge clk); #1;
            clear = 0;
            iv    = 0;
            repeat (L + 2) begin
                @(negedge clk);
                chk($sformatf("clr_no_load C=%0d", C), 128'(ov), 0);
            end
            @(posedge clk); #1;
            ordy = 0;
            send(V1, 0, 0, w);
            lat("lat_rst", L);
            chk($sformatf("rst_pre C=%0d", C), dout, E1);
            @(posedge clk); #3;
            rst_n = 0;
            #1;
            chk($sformatf("arst_dout C=%0d", C), dout, 0);
            chk($sformatf("arst_ov C=%0d", C), 128'(ov), 0);
            @(posedge clk); #1;
            rst_n = 1;
            ordy  = 1;
            rnd   = 1;
            repeat (1000) begin
                s = {$urandom, $urandom, $urandom, $urandom};
                send(mix(s), s, 1, w);
            end
            rnd  = 0;
            ordy = 1;
            w    = 0;
            while (q.size() != 0 && w < 200) begin
                @(negedge clk);
                w++;
            end
            if (q.size() != 0) begin
                total++;
                bad++;
                $display("FAIL drain C=%0d: got %0d pending want 0", C, q.size());
            end
            ndone++;
        end
    end

    initial begin
        int i;
        i = 0;
        while (ndone != 3 && i < 90000) begin
            @(posedge clk);
            i++;
        end
        if (ndone != 3) begin
            total++;
            bad++;
            $display("FAIL watchdog: got %0d finished want 3", ndone);
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/aes_inv_mixcolumns_iter.md
Name: aes_inv_mixcolumns_iter

Overview:
- Iterative inverse AES MixColumns unit for the decryption datapath.
- Accepts a 128-bit state over a valid/ready handshake and applies the InvMixColumns matrix [0e 0b 0d 09] to COLS_PER_CYCLE columns per clock, in place.
- Presents the result on a held output with its own valid/ready handshake.
- Sits between the decrypt round-key adder and the inverse ShiftRows/SubBytes stage, trading latency for area against the forward combinational MixColumns.

Parameters:
- COLS_PER_CYCLE, 1, columns transformed per clock; legal values 1, 2, 4; any other value is a elaboration error.

Ports:
- clk  input  1  clock, all state updates on rising edge
- rst_n  input  1  asynchronous active-low reset
- clear  input  1  synchronous abort; returns block to IDLE, discards the in-flight state
- imx_i  input  128  input state; column c = bits [127-32c -: 32]; byte r of the column = bits [127-32c-8r -: 8]
- in_valid  input  1  imx_i valid
- in_ready  output  1  block can accept imx_i this cycle
- imx_o  output  128  transformed state, same byte mapping as imx_i
- out_valid  output  1  imx_o holds a complete result
- out_ready  input  1  downstream accepts imx_o

Behaviour:
- Reset (rst_n low, asynchronous):
  - state=IDLE, column counter=0, internal state register=0.
  - imx_o=128'h0, out_valid=0, in_ready=1 once reset is released.
- Per-column arithmetic, bytes a0..a3 in GF(2^8) with polynomial 0x11b:
  - b0=0e·a0^0b·a1^0d·a2^09·a3
  - b1=09·a0^0e·a1^0b·a2^0d·a3
  - b2=0d·a0^09·a1^0e·a2^0b·a3
  - b3=0b·a0^0d·a1^09·a2^0e·a3
  - Multiplies are built from xtime only; no lookup tables.
- FSM states IDLE, BUSY, DONE:
  - IDLE: in_ready=1. When in_valid, load imx_i into the state register, set counter=0, go to BUSY.
  - BUSY: in_ready=0, out_valid=0. Each cycle, columns counter..counter+COLS_PER_CYCLE-1 are replaced by their transform; counter advances by COLS_PER_CYCLE. On the cycle that processes column 3, go to DONE.
  - DONE: out_valid=1, imx_o = state register, held stable while out_ready=0.
    - out_ready=1 without in_valid: go to IDLE.
    - Back-to-back: in_ready = out_ready in DONE. If out_ready and in_valid are both high, the result is consumed and the new imx_i is loaded in the same cycle; go to BUSY.
- Latency: handshake accepted at edge N -> out_valid high after edge N+4/COLS_PER_CYCLE.
  - COLS_PER_CYCLE=1 gives 4 cycles; 4 gives 1 cycle.
  - Sustained throughput: one block per 4/COLS_PER_CYCLE+1 cycles with back-to-back handoff.
- imx_o is the registered state; it changes only on load and on BUSY updates. Its value is don't-care while out_valid=0, and it is never combinationally derived from imx_i.
- in_valid while in BUSY: ignored (in_ready=0); the upstream holds data.
- clear:
  - Has priority over all handshakes.
  - Next state IDLE, out_valid=0, counter=0; state register unchanged.
  - Any in_valid in the same cycle as clear is not accepted.
- rst_n asserted mid-BUSY or in DONE: immediate return to reset values; the partial result is lost.
- Counter width is 2 bits and wraps naturally; it is only read in BUSY.

Test Plan:
- Single block, COLS_PER_CYCLE=1: imx_i=8e4da1bc_9fdc589d_01010101_d5d5d7d6 -> after 4 cycles out_valid=1, imx_o=db135345_f20a225c_01010101_d4d4d4d5.
- Back-pressure: same vector, out_ready=0 for 10 cycles -> out_valid and imx_o stable; in_valid meanwhile ignored. Raise out_ready -> one transfer, then IDLE.
- Back-to-back:
  - Second block imx_i=4d7ebdf8_c6c6c6c6_d5d5d7d6_01010101 presented with out_ready=1 in DONE -> load in the same cycle.
  - Expect imx_o=2d26314c_c6c6c6c6_d4d4d4d5_01010101 five cycles after the first result.
- Parameter sweep COLS_PER_CYCLE=2 and 4 on the first vector -> identical imx_o with latency 2 and 1 cycles.
- Abort:
  - clear pulsed during the second BUSY cycle -> next cycle IDLE, out_valid never rises, in_ready=1.
  - rst_n pulsed low asynchronously in DONE -> out_valid=0 and imx_o=0 before the next clock edge.
- Round trip: 1000 random states through forward MixColumns then this block -> output equals the original state.
